// File: rtl/wb_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// wb_stream_reader_pkg
// Shared types and constants for the Wishbone block-read streamer.
//   state_t        : controller states (IDLE, REQ, STALL, GAP, FIN)
//   WB_SEL_ALL     : full-word byte select
//   BYTES_PER_WORD : address increment per 32-bit word
// -----------------------------------------------------------------------------
package wb_stream_reader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        STALL = 3'd2,
        GAP   = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam logic [3:0] WB_SEL_ALL     = 4'hF;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/wb_stream_reader_fifo.sv
// -----------------------------------------------------------------------------
// wb_stream_fifo
// Synchronous first-word-fall-through FIFO, 32-bit words, DEPTH entries
// (power of two, >= 2). o_data always shows the head word when not empty.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (control only)
//   i_push, i_data    : write strobe and word
//   i_pop             : remove head word (ignored when empty)
//   o_data            : head word
//   o_count           : number of stored words (0..DEPTH)
//   o_empty, o_full   : status flags
// A push while full is accepted only together with a pop.
// -----------------------------------------------------------------------------
module wb_stream_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [31:0]              i_data,
    input  logic                     i_pop,
    output logic [31:0]              o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage carries no reset; only pointers and count are control state.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule

// File: rtl/wb_stream_reader.sv
// -----------------------------------------------------------------------------
// wb_stream_reader
// Wishbone classic-cycle read master: fetches nwords 32-bit words starting at
// base_adr and streams them in order on a valid/ready port through an
// internal FIFO, so consumer back-pressure never holds the bus mid-cycle.
// Optional build macro: WB_STREAM_READER_LOOP_EN
//   defined   : continuous rescan of the region; done pulses at every wrap,
//               a start pulse while busy stops the scan after the current cycle
//   undefined : one-shot transfer, start ignored while busy
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   start, base_adr, nwords : launch pulse, byte start address, word count
//   busy, done, error       : status (busy level, end pulse, sticky abort)
//   m_data, m_valid, m_ready: output stream
//   wb_*                    : Wishbone master signals (read only)
// -----------------------------------------------------------------------------
module wb_stream_reader
    import wb_stream_reader_pkg::*;
#(
    parameter int ADR_WIDTH  = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_RETRY  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADR_WIDTH-1:0] base_adr,
    input  logic [CNT_WIDTH-1:0] nwords,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [31:0]          m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 wb_cyc,
    output logic                 wb_stb,
    output logic                 wb_we,
    output logic [3:0]           wb_sel,
    output logic [ADR_WIDTH-1:0] wb_adr,
    output logic [31:0]          wb_dat_ms,
    input  logic [31:0]          wb_dat_sm,
    input  logic                 wb_ack,
    input  logic                 wb_err,
    input  logic                 wb_rty
);

    localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int            RW        = $clog2(MAX_RETRY + 2);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    state_t               r_state;
    state_t               w_next;
    logic [ADR_WIDTH-1:0] r_base;
    logic [CNT_WIDTH-1:0] r_nwords;
    logic [CNT_WIDTH-1:0] r_index;
    logic [RW-1:0]        r_retry;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;

    logic                 w_req;
    logic                 w_start_acc;
    logic                 w_in_req;
    logic                 w_ack;
    logic                 w_err;
    logic                 w_rty;
    logic                 w_last;
    logic                 w_retry_max;
    logic                 w_pop;
    logic                 w_full_next;
    logic                 w_stop;
    logic                 w_end_ack;
    logic                 w_wrap;
    logic [CW-1:0]        w_fifo_count;
    logic                 w_fifo_empty;
    logic                 w_fifo_full;
    logic [31:0]          w_fifo_data;

    // Start is only taken from an idle, non-busy controller.
    assign w_start_acc = start && !r_busy && (r_state == IDLE);

    // Response decode, priority err > rty > ack.
    assign w_in_req    = (r_state == REQ);
    assign w_err       = w_in_req && wb_err;
    assign w_rty       = w_in_req && !wb_err && wb_rty;
    assign w_ack       = w_in_req && !wb_err && !wb_rty && wb_ack;

    assign w_last      = (({1'b0, r_index} + 1'b1) == {1'b0, r_nwords});
    assign w_retry_max = (r_retry == RETRY_LIM);
    assign w_pop       = !w_fifo_empty && m_ready;
    // FIFO occupancy after this cycle's push, net of a same-cycle pop.
    assign w_full_next = ((w_fifo_count + CW'(1) - CW'(w_pop)) == DEPTH_C);

`ifdef WB_STREAM_READER_LOOP_EN
    logic r_stop;

    // Stop request latched from a start pulse seen during a scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stop <= 1'b0;
        end else if (r_state == FIN || w_start_acc) begin
            r_stop <= 1'b0;
        end else if (start && r_busy) begin
            r_stop <= 1'b1;
        end
    end

    assign w_stop    = r_stop;
    assign w_end_ack = r_stop;
    assign w_wrap    = w_ack && w_last && !r_stop;
`else
    assign w_stop    = 1'b0;
    assign w_end_ack = w_last;
    assign w_wrap    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_start_acc) begin
                    if (nwords == '0) begin
                        w_next = FIN;
                    end else if (w_fifo_full) begin
                        // Words from a previous transfer may still fill the FIFO.
                        w_next = STALL;
                    end else begin
                        w_next = REQ;
                    end
                end
            end
            REQ: begin
                if (w_err) begin
                    w_next = FIN;
                end else if (w_rty) begin
                    w_next = w_retry_max ? FIN : GAP;
                end else if (w_ack) begin
                    if (w_end_ack) begin
                        w_next = FIN;
                    end else if (w_full_next) begin
                        w_next = STALL;
                    end else begin
                        w_next = REQ;
                    end
                end
            end
            STALL: begin
                if (w_stop) begin
                    w_next = FIN;
                end else if (!w_fifo_full) begin
                    w_next = REQ;
                end
            end
            GAP: begin
                w_next = w_stop ? FIN : REQ;
            end
            FIN: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Output decode: the bus is driven only while requesting.
    always_comb begin
        w_req = 1'b0;
        unique case (r_state)
            REQ:     w_req = 1'b1;
            default: w_req = 1'b0;
        endcase
    end

    // Transfer bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base   <= '0;
            r_nwords <= '0;
            r_index  <= '0;
            r_retry  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            // done trails FIN by one cycle; busy falls on the cycle after done.
            r_done <= (r_state == FIN) || w_wrap;
            if (w_start_acc) begin
                r_base   <= base_adr & ~(ADR_WIDTH'(BYTES_PER_WORD - 1));
                r_nwords <= nwords;
                r_index  <= '0;
                r_retry  <= '0;
                r_error  <= 1'b0;
                r_busy   <= 1'b1;
            end else begin
                if (r_state == IDLE && r_done) begin
                    r_busy <= 1'b0;
                end
                if (w_ack) begin
                    r_retry <= '0;
                    r_index <= w_last ? '0 : r_index + 1'b1;
                end
                if (w_rty && !w_retry_max) begin
                    r_retry <= r_retry + 1'b1;
                end
                if (w_err || (w_rty && w_retry_max)) begin
                    r_error <= 1'b1;
                end
            end
        end
    end

    wb_stream_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_ack),
        .i_data  (wb_dat_sm),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // Address adder wraps modulo 2^ADR_WIDTH.
    assign wb_adr    = r_base + ADR_WIDTH'(r_index) * ADR_WIDTH'(BYTES_PER_WORD);
    assign wb_cyc    = w_req;
    assign wb_stb    = w_req;
    assign wb_we     = 1'b0;
    assign wb_sel    = WB_SEL_ALL;
    assign wb_dat_ms = '0;

    assign busy    = r_busy;
    assign done    = r_done;
    assign error   = r_error;
    assign m_valid = !w_fifo_empty;
    assign m_data  = w_fifo_data;

endmodule
